ort_pulse_sequencer: RTL and testbench

- Synchronous controller that shares one OR-toggle (ORT) SFQ cell between two requesters, A and B.
- Per transaction it issues a data pulse on the cell's a and/or b line, waits out the data-to-clock critical time, and issues a clock pulse.
- It then checks that the cell output toggles within a timeout, and reports completion or error with transaction and error counters.
- It sits between the digital test/control fabric and the pulse-level cell model; every toggle of a drive line (either edge) is one SFQ pulse.

---
 rtl/ort_pulse_sequencer.sv | 157 +++++++++++++++
 tb/tb_ort_pulse_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ort_pulse_sequencer.sv
// Arbitrates requesters A/B onto one ORT cell: data pulse, clock pulse after SETUP_CYC,
// then waits for the synchronized output toggle or a timeout. Drive lines signal by toggling.
module ort_pulse_sequencer #(
  parameter int SETUP_CYC   = 3,
  parameter int TIMEOUT_CYC = 16,
  parameter int GAP_CYC     = 2,
  parameter int MERGE       = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             drive_a,
  output logic             drive_b,
  output logic             drive_clk,
  input  logic             ort_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] CLKWAIT = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic        last_b;
  logic        sync1, sync2, sync_prev;
  logic        out_evt;
  logic        pick_a, pick_b;

  assign busy    = (state != IDLE);
  assign out_evt = sync2 ^ sync_prev;

  // last_b records which side won the last single-side grant; merged grants leave it alone.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (req_a && req_b) begin
      if (MERGE != 0) begin
        pick_a = 1'b1;
        pick_b = 1'b1;
      end else if (last_b) begin
        pick_a = 1'b1;
      end else begin
        pick_b = 1'b1;
      end
    end else begin
      pick_a = req_a;
      pick_b = req_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= ort_out;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_b    <= 1'b1;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      drive_a   <= 1'b0;
      drive_b   <= 1'b0;
      drive_clk <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      tx_count  <= '0;
      err_count <= '0;
    end else begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;

      // An output toggle outside CLKWAIT is flagged but never disturbs the sequence.
      if (out_evt && state != CLKWAIT) begin
        err      <= 1'b1;
        err_code <= 2'b11;
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (pick_a || pick_b) begin
            gnt_a   <= pick_a;
            gnt_b   <= pick_b;
            drive_a <= drive_a ^ pick_a;
            drive_b <= drive_b ^ pick_b;
            if (pick_a ^ pick_b) last_b <= pick_b;
            cnt     <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            drive_clk <= ~drive_clk;
            cnt       <= '0;
            state     <= CLKWAIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CLKWAIT: begin
          if (out_evt) begin
            done     <= 1'b1;
            err_code <= 2'b00;
            tx_count <= tx_count + CNT_W'(1);
            cnt      <= '0;
            state    <= RECOVER;
          end else if (cnt == TO_LAST) begin
            done     <= 1'b1;
            err      <= 1'b1;
            err_code <= 2'b01;
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
            cnt      <= '0;
            state    <= RECOVER;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (cnt >= GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ort_pulse_sequencer.sv
// Directed bench: u0 is the default arbitrating build, u1 a merged build with 2-bit counters.
module tb_ort_pulse_sequencer;

  logic clk, rst_n;
  logic req_a, req_b, req_a1, req_b1;
  logic gnt_a, gnt_b, drive_a, drive_b, drive_clk, busy, done, err;
  logic gnt_a1, gnt_b1, drive_a1, drive_b1, drive_clk1, busy1, done1, err1;
  logic [1:0]  err_code, err_code1;
  logic [15:0] tx_count, err_count;
  logic [1:0]  tx_count1, err_count1;
  logic ort_m, ort_s, ort_out;
  logic ort1_m, ort1_s, ort1_out;
  logic model_en;

  int vectors = 0;
  int miscompares = 0;
  int n_a = 0, n_b = 0, n_c = 0, n_c1 = 0, n_o1 = 0;
  int base_a, base_b, base_c, w;

  assign ort_out  = ort_m ^ ort_s;
  assign ort1_out = ort1_m ^ ort1_s;

  ort_pulse_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .drive_a(drive_a), .drive_b(drive_b),
    .drive_clk(drive_clk), .ort_out(ort_out), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .tx_count(tx_count), .err_count(err_count)
  );

  ort_pulse_sequencer #(.MERGE(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a1), .req_b(req_b1),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .drive_a(drive_a1), .drive_b(drive_b1),
    .drive_clk(drive_clk1), .ort_out(ort1_out), .busy(busy1), .done(done1),
    .err(err1), .err_code(err_code1), .tx_count(tx_count1), .err_count(err_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell models: output toggles shortly after each clock pulse; reset alongside the controller.
  always begin
    @(drive_clk or negedge rst_n);
    if (!rst_n) ort_m = 1'b0;
    else begin
      #2;
      if (model_en && rst_n) ort_m = ~ort_m;
    end
  end

  always begin
    @(drive_clk1 or negedge rst_n);
    if (!rst_n) ort1_m = 1'b0;
    else begin
      #2;
      if (rst_n) ort1_m = ~ort1_m;
    end
  end

  always @(drive_a)    if (rst_n) n_a++;
  always @(drive_b)    if (rst_n) n_b++;
  always @(drive_clk)  if (rst_n) n_c++;
  always @(drive_clk1) if (rst_n) n_c1++;
  always @(ort1_m)     if (rst_n) n_o1++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_a = 0; req_b = 0; req_a1 = 0; req_b1 = 0;
    model_en = 1'b0; ort_s = 1'b0; ort1_s = 1'b0;
    tick(2);
    chk("rst_gnt",   {30'd0, gnt_a, gnt_b}, 0);
    chk("rst_drive", {29'd0, drive_a, drive_b, drive_clk}, 0);
    chk("rst_flags", {29'd0, busy, done, err}, 0);
    chk("rst_code",  {30'd0, err_code}, 0);
    chk("rst_cnts",  {tx_count, err_count}, 0);
    rst_n = 1'b1; model_en = 1'b1;
    tick(2);

    // Single A transaction.
    req_a = 1;
    tick(1);
    chk("t1_gnt",   {30'd0, gnt_a, gnt_b}, 32'b10);
    chk("t1_drv",   {29'd0, drive_a, busy, drive_clk}, 32'b110);
    req_a = 0;
    tick(2);
    chk("t1_clk_e2", {31'd0, drive_clk}, 0);
    tick(1);
    chk("t1_clk_e3", {31'd0, drive_clk}, 1);
    tick(2);
    chk("t1_done_e5", {31'd0, done}, 0);
    tick(1);
    chk("t1_done_e6", {29'd0, done, err_code}, 32'b100);
    chk("t1_tx",      {16'd0, tx_count}, 1);
    tick(2);
    chk("t1_busy_e8", {31'd0, busy}, 1);
    tick(1);
    chk("t1_busy_e9", {31'd0, busy}, 0);

    // Spurious toggle while idle.
    ort_s = 1'b1;
    tick(2);
    chk("sp_err_early", {31'd0, err}, 0);
    tick(1);
    chk("sp_err",   {28'd0, err, err_code, busy}, 32'b1110);
    chk("sp_cnt",   {16'd0, err_count}, 1);
    tick(1);
    chk("sp_hold",  {29'd0, err, err_code}, 32'b011);

    // Stuck output: timeout, then recovery and a good transaction.
    model_en = 1'b0;
    req_a = 1;
    tick(1);
    chk("to_gnt", {31'd0, gnt_a}, 1);
    req_a = 0;
    tick(18);
    chk("to_done_e18", {31'd0, done}, 0);
    tick(1);
    chk("to_done_e19", {28'd0, done, err, err_code}, 32'b1101);
    chk("to_errcnt",   {16'd0, err_count}, 2);
    req_a = 1;
    tick(3);
    chk("to_gap", {30'd0, gnt_a, busy}, 0);
    tick(1);
    chk("to_regnt", {31'd0, gnt_a}, 1);
    req_a = 0; model_en = 1'b1;
    tick(6);
    chk("to_ok", {28'd0, done, err, err_code}, 32'b1000);
    chk("to_tx", {16'd0, tx_count}, 2);
    tick(4);
    chk("to_idle", {31'd0, busy}, 0);

    // Reset in CLKWAIT.
    req_a = 1;
    tick(1);
    req_a = 0;
    tick(4);
    chk("rc_busy_pre", {31'd0, busy}, 1);
    model_en = 1'b0; rst_n = 1'b0; ort_s = 1'b0;
    #1;
    chk("rc_flags", {27'd0, busy, done, err, err_code}, 0);
    chk("rc_cnts",  {tx_count, err_count}, 0);
    chk("rc_drive", {29'd0, drive_a, drive_b, drive_clk}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rc_nodone", {30'd0, done, err}, 0);
    model_en = 1'b1; req_a = 1; req_b = 1;
    tick(1);
    chk("rc_afirst", {30'd0, gnt_a, gnt_b}, 32'b10);
    req_a = 0;
    tick(10);
    chk("rc_bnext", {30'd0, gnt_a, gnt_b}, 32'b01);
    req_b = 0;
    tick(9);
    chk("rc_end", {busy, 15'd0, tx_count}, 2);
    chk("rc_errs", {16'd0, err_count}, 0);

    // Round robin, four back-to-back transactions.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    base_a = n_a; base_b = n_b; base_c = n_c;
    req_a = 1; req_b = 1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      do begin
        tick(1);
        w++;
      end while (!(gnt_a || gnt_b) && w < 15);
      chk("rr_wait", {31'd0, w < 15}, 1);
      chk("rr_order", {30'd0, gnt_a, gnt_b}, (i % 2 == 0) ? 32'b10 : 32'b01);
    end
    req_a = 0; req_b = 0;
    tick(9);
    chk("rr_idle", {31'd0, busy}, 0);
    chk("rr_tx",   {tx_count, err_count}, {16'd4, 16'd0});
    chk("rr_tog_a", n_a - base_a, 2);
    chk("rr_tog_b", n_b - base_b, 2);
    chk("rr_tog_c", n_c - base_c, 4);

    // Merged build: one transaction for simultaneous requests.
    base_c = n_c1;
    req_a1 = 1; req_b1 = 1;
    tick(1);
    chk("mg_gnt", {28'd0, gnt_a1, gnt_b1, drive_a1, drive_b1}, 32'b1111);
    req_a1 = 0; req_b1 = 0;
    tick(9);
    chk("mg_end",  {29'd0, busy1, tx_count1}, 1);
    chk("mg_clk",  n_c1 - base_c, 1);
    chk("mg_out",  n_o1, 1);
    chk("mg_errs", {30'd0, err_count1}, 0);

    // Error counter saturates at all-ones.
    for (int i = 0; i < 4; i++) begin
      ort1_s = ~ort1_s;
      tick(4);
    end
    chk("sat_cnt",  {30'd0, err_count1}, 3);
    chk("sat_code", {30'd0, err_code1}, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
